// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg
//   Shared definitions for the instruction prefetch unit:
//   - fetch_state_t : IDLE (no read outstanding) / WAIT (one read outstanding)
//   - PC_OFFSET     : offset added to an instruction's byte address to form pc_out
//   - instr_bytes() : fetch stride in bytes for a given instruction width
//   - fifo_entry_w(): width of one prefetch FIFO entry {instruction, address}
package instr_fetch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_t;

  localparam int PC_OFFSET = 4;

  function automatic int instr_bytes(input int instr_w);
    return instr_w / 8;
  endfunction

  function automatic int fifo_entry_w(input int instr_w, input int addr_w);
    return instr_w + addr_w;
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo
//   DEPTH x WIDTH circular FIFO holding prefetched {instruction, address} entries.
//   Ports:
//     clk, reset_n     : clock, asynchronous active-low reset
//     flush            : synchronous empty; wins over push and pop
//     push, wr_data    : write wr_data at the tail
//     pop              : discard the head entry
//     rd_data          : head entry (meaningful only while count != 0)
//     count            : number of stored entries, 0..DEPTH
//   DEPTH must be a power of two so the pointers wrap for free.
module prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 28
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage needs no reset: reads are only trusted while count != 0.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      storage[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      // Simultaneous push and pop leave the occupancy unchanged.
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  assign rd_data = storage[rd_ptr];

endmodule

// File: rtl/instruction_prefetch_unit.sv
// instruction_prefetch_unit
//   Fetch stage that keeps one instruction-memory read in flight and buffers
//   returned instructions in a DEPTH-entry FIFO ahead of the decoder.
//   Ports:
//     clk, reset_n                   : clock, asynchronous active-low reset
//     mem_read_enable, mem_address   : read request to instruction memory
//     mem_instruction, mem_stall     : read data (valid the cycle after the
//                                      request once mem_stall is low)
//     decoder_stall                  : decoder cannot take the head this cycle
//     branch_valid, branch_target    : flush and redirect fetch
//     instr_valid, instr_out, pc_out : FIFO head towards the decoder
//                                      (pc_out = zero-extended address + 4)
module instruction_prefetch_unit
  import instr_fetch_pkg::*;
#(
  parameter int              ADDR_W   = 12,
  parameter int              INSTR_W  = 16,
  parameter int              PC_W     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               mem_read_enable,
  output logic [ADDR_W-1:0]  mem_address,
  input  logic [INSTR_W-1:0] mem_instruction,
  input  logic               mem_stall,
  input  logic               decoder_stall,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc_out
);

  localparam int INSTR_BYTES = instr_bytes(INSTR_W);
  localparam int ENTRY_W     = fifo_entry_w(INSTR_W, ADDR_W);
  localparam int CNT_W       = $clog2(DEPTH) + 1;

  fetch_state_t        state, state_next;
  logic [ADDR_W-1:0]   fetch_addr;
  logic [ADDR_W-1:0]   req_addr;
  logic                drop;
  logic [CNT_W-1:0]    fifo_count;
  logic [ENTRY_W-1:0]  head;
  logic [INSTR_W-1:0]  head_instr;
  logic [PC_W-1:0]     head_pc;
  logic [INSTR_W-1:0]  held_instr;
  logic [PC_W-1:0]     held_pc;
  logic                ret, push, pop, issue;
  logic [CNT_W:0]      fill_level;

  // Handshake decode. fill_level is the FIFO occupancy after this edge,
  // counting the returning read, so a new request is only made when its
  // data is guaranteed a free slot.
  always_comb begin
    ret        = (state == WAIT) && !mem_stall;
    push       = ret && !drop && !branch_valid;
    pop        = instr_valid && !decoder_stall && !branch_valid;
    fill_level = {1'b0, fifo_count}
               + {{CNT_W{1'b0}}, (ret && !drop)}
               - {{CNT_W{1'b0}}, pop};
    issue      = reset_n && !branch_valid && ((state == IDLE) || ret)
               && (fill_level < (CNT_W+1)'(DEPTH));
  end

  // Next-state logic: a branch suppresses issue, so a returning read during a
  // branch falls back to IDLE, while a stalled one stays in WAIT to be dropped.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (issue)        state_next = WAIT;
      WAIT:    if (ret && !issue) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM register, fetch address, drop flag and the held decoder outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      fetch_addr <= RESET_PC;
      req_addr   <= '0;
      drop       <= 1'b0;
      held_instr <= '0;
      held_pc    <= '0;
    end else begin
      state <= state_next;
      if (branch_valid) begin
        fetch_addr <= branch_target;
        drop       <= (state == WAIT) && !ret;
      end else begin
        if (issue) begin
          fetch_addr <= fetch_addr + ADDR_W'(INSTR_BYTES);
          req_addr   <= fetch_addr;
        end
        if (ret) drop <= 1'b0;
      end
      if (instr_valid) begin
        held_instr <= head_instr;
        held_pc    <= head_pc;
      end
    end
  end

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (branch_valid),
    .push    (push),
    .pop     (pop),
    .wr_data ({mem_instruction, req_addr}),
    .rd_data (head),
    .count   (fifo_count)
  );

  // When the FIFO runs dry the decoder sees the last head it was shown.
  assign instr_valid     = (fifo_count != '0);
  assign head_instr      = head[ENTRY_W-1 -: INSTR_W];
  assign head_pc         = PC_W'(head[ADDR_W-1:0]) + PC_W'(PC_OFFSET);
  assign instr_out       = instr_valid ? head_instr : held_instr;
  assign pc_out          = instr_valid ? head_pc : held_pc;
  assign mem_read_enable = issue;
  assign mem_address     = fetch_addr;

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// tb_instruction_prefetch_unit
//   Directed bench for instruction_prefetch_unit. The memory model answers
//   the last requested address with {4'hC, address}. Inputs are driven 1 ns
//   after each rising edge and outputs are checked 1 ns later.
module tb_instruction_prefetch_unit;

  localparam int ADDR_W  = 12;
  localparam int INSTR_W = 16;
  localparam int PC_W    = 32;
  localparam int DEPTH   = 4;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               mem_read_enable;
  logic [ADDR_W-1:0]  mem_address;
  logic [INSTR_W-1:0] mem_instruction;
  logic               mem_stall;
  logic               decoder_stall;
  logic               branch_valid;
  logic [ADDR_W-1:0]  branch_target;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr_out;
  logic [PC_W-1:0]    pc_out;
  logic [ADDR_W-1:0]  pending_addr = '0;

  int compared   = 0;
  int mismatched = 0;

  instruction_prefetch_unit #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .PC_W     (PC_W),
    .DEPTH    (DEPTH),
    .RESET_PC (12'h000)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .mem_read_enable (mem_read_enable),
    .mem_address     (mem_address),
    .mem_instruction (mem_instruction),
    .mem_stall       (mem_stall),
    .decoder_stall   (decoder_stall),
    .branch_valid    (branch_valid),
    .branch_target   (branch_target),
    .instr_valid     (instr_valid),
    .instr_out       (instr_out),
    .pc_out          (pc_out)
  );

  always #5 clk = ~clk;

  // Simple memory: remembers the last requested address and returns its word.
  always @(posedge clk) begin
    if (mem_read_enable) pending_addr <= mem_address;
  end
  assign mem_instruction = {4'hC, pending_addr};

  function automatic logic [15:0] memWord(input logic [11:0] a);
    return {4'hC, a};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic ms, input logic ds,
                               input logic bv, input logic [11:0] bt);
    @(posedge clk);
    #1;
    reset_n       = rst;
    mem_stall     = ms;
    decoder_stall = ds;
    branch_valid  = bv;
    branch_target = bt;
    #1;
  endtask

  task automatic checkFetch(input string tag, input logic en, input logic [11:0] addr);
    checkOutput({tag, "_re"}, 32'(mem_read_enable), 32'(en));
    if (en) checkOutput({tag, "_addr"}, 32'(mem_address), 32'(addr));
  endtask

  task automatic checkHead(input string tag, input logic [11:0] addr);
    checkOutput({tag, "_valid"}, 32'(instr_valid), 32'd1);
    checkOutput({tag, "_instr"}, 32'(instr_out), 32'(memWord(addr)));
    checkOutput({tag, "_pc"}, pc_out, 32'(addr) + 32'd4);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_re"}, 32'(mem_read_enable), 32'd0);
    checkOutput({tag, "_addr"}, 32'(mem_address), 32'd0);
    checkOutput({tag, "_valid"}, 32'(instr_valid), 32'd0);
    checkOutput({tag, "_instr"}, 32'(instr_out), 32'd0);
    checkOutput({tag, "_pc"}, pc_out, 32'd0);
  endtask

  task automatic restart();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
  endtask

  initial begin
    reset_n       = 1'b0;
    mem_stall     = 1'b0;
    decoder_stall = 1'b0;
    branch_valid  = 1'b0;
    branch_target = '0;
    #2;
    $display("[TB] reset state");
    checkReset("rst");

    // Streaming: one read per cycle, first instruction two cycles after release.
    $display("[TB] streaming fetch");
    restart();
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
      checkFetch($sformatf("s1c%0d", c), 1'b1, 12'(2*c));
      if (c >= 2) checkHead($sformatf("s1c%0d", c), 12'(2*(c-2)));
      else checkOutput($sformatf("s1c%0d_valid", c), 32'(instr_valid), 32'd0);
    end

    // Decoder stall: FIFO fills to DEPTH, then drains in order.
    $display("[TB] decoder stall");
    restart();
    for (int c = 0; c < 11; c++) begin
      applyStimulus(1'b1, 1'b0, (c >= 1 && c <= 5), 1'b0, 12'h000);
      if (c <= 3) checkFetch($sformatf("s2c%0d", c), 1'b1, 12'(2*c));
      if (c == 4 || c == 5) checkFetch($sformatf("s2c%0d", c), 1'b0, 12'h000);
      if (c == 6) checkFetch("s2c6", 1'b1, 12'h008);
      if (c == 7) checkFetch("s2c7", 1'b1, 12'h00A);
      if (c == 2 || c == 5) checkHead($sformatf("s2c%0d", c), 12'h000);
      if (c >= 6) checkHead($sformatf("s2c%0d", c), 12'(2*(c-6)));
    end

    // Memory stall on the read of 0x006 for five cycles.
    $display("[TB] memory stall");
    restart();
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b1, (c >= 4 && c <= 8), 1'b0, 1'b0, 12'h000);
      if (c == 3) checkHead("s3c3", 12'h002);
      if (c == 4 || c == 6 || c == 8) checkFetch($sformatf("s3c%0d", c), 1'b0, 12'h000);
      if (c == 6) begin
        checkOutput("s3c6_valid", 32'(instr_valid), 32'd0);
        checkOutput("s3c6_hold_instr", 32'(instr_out), 32'(memWord(12'h004)));
        checkOutput("s3c6_hold_pc", pc_out, 32'h8);
      end
      if (c == 9) checkFetch("s3c9", 1'b1, 12'h008);
      if (c == 10) checkHead("s3c10", 12'h006);
      if (c == 11) checkHead("s3c11", 12'h008);
    end

    // Branch while the read of 0x00A is stalled: its data must be dropped.
    $display("[TB] branch during stalled read");
    restart();
    for (int c = 0; c < 11; c++) begin
      applyStimulus(1'b1, (c == 6 || c == 7), 1'b0, (c == 6), (c == 6) ? 12'h100 : 12'h000);
      if (c == 5) checkFetch("s4c5", 1'b1, 12'h00A);
      if (c == 6) checkFetch("s4c6", 1'b0, 12'h000);
      if (c == 7) begin
        checkOutput("s4c7_valid", 32'(instr_valid), 32'd0);
        checkFetch("s4c7", 1'b0, 12'h000);
        checkOutput("s4c7_hold_instr", 32'(instr_out), 32'(memWord(12'h008)));
      end
      if (c == 8) checkFetch("s4c8", 1'b1, 12'h100);
      if (c == 9) begin
        checkOutput("s4c9_valid", 32'(instr_valid), 32'd0);
        checkFetch("s4c9", 1'b1, 12'h102);
      end
      if (c == 10) checkHead("s4c10", 12'h100);
    end

    // Branch in the same cycle as a pop and a returning read.
    $display("[TB] branch with pop and return");
    restart();
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, (c == 4), (c == 4) ? 12'h200 : 12'h000);
      if (c == 4) begin
        checkHead("s5c4", 12'h004);
        checkFetch("s5c4", 1'b0, 12'h000);
      end
      if (c == 5 || c == 6) begin
        checkOutput($sformatf("s5c%0d_valid", c), 32'(instr_valid), 32'd0);
        checkFetch($sformatf("s5c%0d", c), 1'b1, 12'(12'h200 + 2*(c-5)));
      end
      if (c == 7) checkHead("s5c7", 12'h200);
    end

    // Reset asserted while waiting on memory with three entries buffered.
    $display("[TB] reset mid-operation");
    restart();
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b1, (c == 4), (c >= 1), 1'b0, 12'h000);
    end
    checkHead("s6c4", 12'h000);
    checkFetch("s6c4", 1'b0, 12'h000);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
    checkReset("s6rst");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
      if (c < 2) checkFetch($sformatf("s6r%0d", c), 1'b1, 12'(2*c));
      if (c == 1) checkOutput("s6r1_valid", 32'(instr_valid), 32'd0);
      if (c == 2) checkHead("s6r2", 12'h000);
    end

    // Address wrap at the top of the address space.
    $display("[TB] address wrap");
    restart();
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, (c == 0), (c == 0) ? 12'hFFE : 12'h000);
      if (c == 0) checkFetch("s7c0", 1'b0, 12'h000);
      if (c == 1) checkFetch("s7c1", 1'b1, 12'hFFE);
      if (c == 2) checkFetch("s7c2", 1'b1, 12'h000);
      if (c == 3) begin
        checkOutput("s7c3_valid", 32'(instr_valid), 32'd1);
        checkOutput("s7c3_instr", 32'(instr_out), 32'(memWord(12'hFFE)));
      end
      if (c == 4) checkHead("s7c4", 12'h000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
